// File: rtl/btb_pkg.sv
// btb_pkg: shared types and constants for the fetch-side branch target buffer.
//   BTB_ENTRIES_DEF : default table depth
//   BTB_TAG_MAX_W   : widest possible tag (PC[31:2] with a 0-bit index)
//   btb_entry_t     : one table entry {valid, tag, target, ctr}
//   CTR_WNT/CTR_WT  : weakly-not-taken / weakly-taken counter values
package btb_pkg;

  localparam int BTB_ENTRIES_DEF = 16;
  localparam int BTB_TAG_MAX_W   = 30;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  // Tag is stored zero-extended to the maximum width so the struct does not
  // depend on the table depth chosen by the instantiating module.
  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_MAX_W-1:0] tag;
    logic [31:0]              target;
    logic [1:0]               ctr;
  } btb_entry_t;

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// sat_counter2: combinational next value of a 2-bit saturating direction
// counter.
//   ctr_i   : current counter value
//   taken_i : resolved direction (1 = taken)
//   ctr_o   : next counter value, saturating at 0 and 3
module sat_counter2
  import btb_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  // Step toward the resolved direction, holding at the end stops.
  always_comb begin
    ctr_o = ctr_i;
    case ({taken_i, ctr_i})
      {1'b1, CTR_SNT}: ctr_o = CTR_WNT;
      {1'b1, CTR_WNT}: ctr_o = CTR_WT;
      {1'b1, CTR_WT }: ctr_o = CTR_ST;
      {1'b1, CTR_ST }: ctr_o = CTR_ST;
      {1'b0, CTR_SNT}: ctr_o = CTR_SNT;
      {1'b0, CTR_WNT}: ctr_o = CTR_SNT;
      {1'b0, CTR_WT }: ctr_o = CTR_WNT;
      {1'b0, CTR_ST }: ctr_o = CTR_WT;
      default:         ctr_o = ctr_i;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit direction counters.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   if_pc_i                : fetch PC, looked up combinationally
//   br_sel_BTB_o, pc_BTB_o : predicted-taken flag and predicted next PC
//   ex_*                   : branch/jump resolution from EX, trains the table
//   flush_i                : invalidate every entry (fence.i)
//   br_count_o             : resolved control-flow instruction count
//   mispred_count_o        : misprediction count
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES_DEF,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] if_pc_i,
  output logic        br_sel_BTB_o,
  output logic [31:0] pc_BTB_o,
  input  logic        ex_update_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_target_i,
  input  logic        flush_i,
  output logic [31:0] br_count_o,
  output logic [31:0] mispred_count_o
);

  btb_entry_t r_table [ENTRIES];
  logic [31:0] r_br_count;
  logic [31:0] r_mispred_count;

  logic [IDX_W-1:0]         w_lk_idx;
  logic [BTB_TAG_MAX_W-1:0] w_lk_tag;
  btb_entry_t               w_lk_entry;
  logic                     w_lk_hit;

  logic [IDX_W-1:0]         w_up_idx;
  logic [BTB_TAG_MAX_W-1:0] w_up_tag;
  btb_entry_t               w_up_entry;
  logic                     w_up_hit;
  logic [1:0]               w_ctr_next;
  logic                     w_mispred;
  logic [1:0]               w_unused_pc_lsb;

  // The two low PC bits never select an entry (word-aligned fetch).
  assign w_unused_pc_lsb = ex_pc_i[1:0];

  assign w_lk_idx   = if_pc_i[IDX_W+1:2];
  assign w_lk_tag   = {{IDX_W{1'b0}}, if_pc_i[31:IDX_W+2]};
  assign w_lk_entry = r_table[w_lk_idx];

  assign w_up_idx   = ex_pc_i[IDX_W+1:2];
  assign w_up_tag   = {{IDX_W{1'b0}}, ex_pc_i[31:IDX_W+2]};
  assign w_up_entry = r_table[w_up_idx];

  sat_counter2 u_sat_counter2 (
    .ctr_i   (w_up_entry.ctr),
    .taken_i (ex_taken_i),
    .ctr_o   (w_ctr_next)
  );

  // Lookup: reads the registered table only, so same-cycle updates are not bypassed.
  always_comb begin
    w_lk_hit     = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);
    br_sel_BTB_o = w_lk_hit && w_lk_entry.ctr[1];
    if (br_sel_BTB_o) begin
      pc_BTB_o = w_lk_entry.target;
    end else begin
      pc_BTB_o = if_pc_i + 32'd4;
    end
  end

  // Update-side hit and misprediction detection.
  always_comb begin
    w_up_hit  = w_up_entry.valid && (w_up_entry.tag == w_up_tag);
    w_mispred = (ex_taken_i != ex_pred_taken_i) ||
                (ex_taken_i && ex_pred_taken_i && (ex_target_i != ex_pred_target_i));
  end

  // Table training, flush and statistics.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= '0;
      end
      r_br_count      <= 32'd0;
      r_mispred_count <= 32'd0;
    end else begin
      if (ex_update_i) begin
        r_br_count <= r_br_count + 32'd1;
        if (w_mispred) begin
          r_mispred_count <= r_mispred_count + 32'd1;
        end
        if (w_up_hit) begin
          r_table[w_up_idx].ctr <= w_ctr_next;
          if (ex_taken_i) begin
            r_table[w_up_idx].target <= ex_target_i;
          end
        end else if (ex_taken_i) begin
          r_table[w_up_idx].valid  <= 1'b1;
          r_table[w_up_idx].tag    <= w_up_tag;
          r_table[w_up_idx].target <= ex_target_i;
          r_table[w_up_idx].ctr    <= CTR_WT;
        end
      end
      // Placed after the update so a same-cycle allocation is also invalidated.
      if (flush_i) begin
        for (int i = 0; i < ENTRIES; i++) begin
          r_table[i].valid <= 1'b0;
        end
      end
    end
  end

  assign br_count_o      = r_br_count;
  assign mispred_count_o = r_mispred_count;

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed self-checking bench for branch_target_buffer.
module tb_branch_target_buffer;
  import btb_pkg::*;

  logic        clk_i;
  logic        rst_ni;
  logic [31:0] if_pc_i;
  logic        br_sel_BTB_o;
  logic [31:0] pc_BTB_o;
  logic        ex_update_i;
  logic [31:0] ex_pc_i;
  logic        ex_taken_i;
  logic [31:0] ex_target_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pred_target_i;
  logic        flush_i;
  logic [31:0] br_count_o;
  logic [31:0] mispred_count_o;

  int checks = 0;
  int errors = 0;

  branch_target_buffer #(.ENTRIES(16)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .if_pc_i          (if_pc_i),
    .br_sel_BTB_o     (br_sel_BTB_o),
    .pc_BTB_o         (pc_BTB_o),
    .ex_update_i      (ex_update_i),
    .ex_pc_i          (ex_pc_i),
    .ex_taken_i       (ex_taken_i),
    .ex_target_i      (ex_target_i),
    .ex_pred_taken_i  (ex_pred_taken_i),
    .ex_pred_target_i (ex_pred_target_i),
    .flush_i          (flush_i),
    .br_count_o       (br_count_o),
    .mispred_count_o  (mispred_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Combinational lookup of one PC.
  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_sel, input logic [31:0] exp_pc);
    if_pc_i = pc;
    #1;
    check({tag, ".sel"}, {31'd0, br_sel_BTB_o}, {31'd0, exp_sel});
    check({tag, ".pc"}, pc_BTB_o, exp_pc);
  endtask

  task automatic counts(input string tag, input logic [31:0] exp_br, input logic [31:0] exp_mis);
    check({tag, ".br_cnt"}, br_count_o, exp_br);
    check({tag, ".mis_cnt"}, mispred_count_o, exp_mis);
  endtask

  // One update cycle; inputs change 1 time unit after the edge.
  task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                        input logic ptaken, input logic [31:0] ptgt);
    ex_update_i      = 1'b1;
    ex_pc_i          = pc;
    ex_taken_i       = taken;
    ex_target_i      = tgt;
    ex_pred_taken_i  = ptaken;
    ex_pred_target_i = ptgt;
    @(posedge clk_i);
    #1;
    ex_update_i = 1'b0;
    flush_i     = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; if_pc_i = 32'h0; ex_update_i = 1'b0; ex_pc_i = 32'h0;
    ex_taken_i = 1'b0; ex_target_i = 32'h0; ex_pred_taken_i = 1'b0;
    ex_pred_target_i = 32'h0; flush_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Reset state
    lookup("rst_lk", 32'h100, 1'b0, 32'h104);
    counts("rst", 32'd0, 32'd0);
    lookup("wrap_pc4", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // Allocation: ctr=2
    update(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    lookup("alloc", 32'h100, 1'b1, 32'h200);
    counts("alloc", 32'd1, 32'd1);

    // Correct taken: ctr=3
    update(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    counts("ok_taken", 32'd2, 32'd1);
    // NT #1: ctr=2, still taken
    update(32'h100, 1'b0, 32'h104, 1'b1, 32'h200);
    lookup("nt1", 32'h100, 1'b1, 32'h200);
    counts("nt1", 32'd3, 32'd2);
    // NT #2: ctr=1, not taken
    update(32'h100, 1'b0, 32'h104, 1'b1, 32'h200);
    lookup("nt2", 32'h100, 1'b0, 32'h104);
    counts("nt2", 32'd4, 32'd3);
    // NT #3 correctly predicted: ctr=0
    update(32'h100, 1'b0, 32'h104, 1'b0, 32'h104);
    lookup("nt3", 32'h100, 1'b0, 32'h104);
    counts("nt3", 32'd5, 32'd3);
    // NT #4 at floor: ctr stays 0
    update(32'h100, 1'b0, 32'h104, 1'b0, 32'h104);
    counts("nt4", 32'd6, 32'd3);
    // Taken from 0 -> 1: still not taken (proves floor held)
    update(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    lookup("sat0", 32'h100, 1'b0, 32'h104);
    counts("sat0", 32'd7, 32'd4);
    // Taken 1 -> 2 with new target 0x300
    update(32'h100, 1'b1, 32'h300, 1'b0, 32'h104);
    lookup("up2", 32'h100, 1'b1, 32'h300);
    counts("up2", 32'd8, 32'd5);
    // Target mispredict: predicted 0x300, actual 0x400
    update(32'h100, 1'b1, 32'h400, 1'b1, 32'h300);
    lookup("tgt_mis", 32'h100, 1'b1, 32'h400);
    counts("tgt_mis", 32'd9, 32'd6);

    // Alias: 0x140 shares index 0, evicts 0x100
    update(32'h140, 1'b1, 32'h500, 1'b0, 32'h144);
    lookup("evicted", 32'h100, 1'b0, 32'h104);
    lookup("alias", 32'h140, 1'b1, 32'h500);
    counts("alias", 32'd10, 32'd7);
    // Miss not-taken leaves the table alone
    update(32'h180, 1'b0, 32'h184, 1'b0, 32'h184);
    lookup("miss_nt", 32'h140, 1'b1, 32'h500);
    lookup("miss_nt_pc", 32'h180, 1'b0, 32'h184);
    counts("miss_nt", 32'd11, 32'd7);

    // Same-cycle lookup/update: old value first, new value after the edge
    if_pc_i          = 32'h140;
    ex_update_i      = 1'b1;
    ex_pc_i          = 32'h140;
    ex_taken_i       = 1'b0;
    ex_target_i      = 32'h144;
    ex_pred_taken_i  = 1'b1;
    ex_pred_target_i = 32'h500;
    #1;
    check("same_cyc_old.sel", {31'd0, br_sel_BTB_o}, 32'd1);
    check("same_cyc_old.pc", pc_BTB_o, 32'h500);
    @(posedge clk_i); #1;
    ex_update_i = 1'b0;
    lookup("same_cyc_new", 32'h140, 1'b0, 32'h144);
    counts("same_cyc", 32'd12, 32'd8);

    // Second entry at index 2
    update(32'h108, 1'b1, 32'h600, 1'b0, 32'h10C);
    lookup("idx2", 32'h108, 1'b1, 32'h600);
    counts("idx2", 32'd13, 32'd9);

    // Flush with update: everything invalid, update still counted
    flush_i = 1'b1;
    update(32'h10C, 1'b1, 32'h700, 1'b0, 32'h110);
    lookup("flush_a", 32'h10C, 1'b0, 32'h110);
    lookup("flush_b", 32'h108, 1'b0, 32'h10C);
    counts("flush", 32'd14, 32'd10);

    // Reset during training drops the update and clears everything
    update(32'h100, 1'b1, 32'h800, 1'b0, 32'h104);
    lookup("pre_rst", 32'h100, 1'b1, 32'h800);
    counts("pre_rst", 32'd15, 32'd11);
    rst_ni = 1'b0;
    update(32'h104, 1'b1, 32'h900, 1'b0, 32'h108);
    rst_ni = 1'b1;
    lookup("post_rst_a", 32'h100, 1'b0, 32'h104);
    lookup("post_rst_b", 32'h104, 1'b0, 32'h108);
    counts("post_rst", 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Fetch-side branch predictor that produces the predicted-taken flag and predicted target consumed downstream as `br_sel_BTB` / `pc_BTB`. Direct-mapped table indexed by the IF-stage PC; it is trained by the branch/jump resolution arriving from the EX stage. The hazard unit compares this prediction against the EX outcome and issues the flush/restore. This block also keeps resolved-branch and misprediction statistics.

## Interface
Parameters:
- `ENTRIES`, 16: table depth; power of two, at least 2.
- `IDX_W`, `$clog2(ENTRIES)`: index width.
- `TAG_W`, `30-IDX_W`: tag width, taken from PC[31:IDX_W+2].

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: reset, synchronous, active-low.
- `if_pc_i` in 32: PC of the instruction being fetched.
- `br_sel_BTB_o` out 1: predicted taken.
- `pc_BTB_o` out 32: predicted next PC.
- `ex_update_i` in 1: the EX instruction is BRANCH/JAL/JALR and the EX stage is enabled.
- `ex_pc_i` in 32: PC of the EX instruction.
- `ex_taken_i` in 1: resolved taken (`br_sel`).
- `ex_target_i` in 32: resolved target (ALU result).
- `ex_pred_taken_i` in 1: `br_sel_BTB_o` value carried down the pipeline with the instruction.
- `ex_pred_target_i` in 32: `pc_BTB_o` value carried down the pipeline with the instruction.
- `flush_i` in 1: invalidate the whole table (fence.i).
- `br_count_o` out 32: number of resolved control-flow instructions.
- `mispred_count_o` out 32: number of mispredictions.

## Operation
- Each entry holds: `valid`, `tag[TAG_W]`, `target[32]`, `ctr[2]`. `ctr` is a 2-bit saturating counter; values 0/1 mean not-taken, 2/3 mean taken.
- Lookup is combinational:
  - idx = `if_pc_i[IDX_W+1:2]`.
  - hit = `valid[idx]` and the tag matches.
  - `br_sel_BTB_o` = hit and `ctr[1]`.
  - `pc_BTB_o` = `target` if `br_sel_BTB_o`, otherwise `if_pc_i + 4` (mod 2^32).
- Update happens at the clock edge when `ex_update_i` is high. Index and tag come from `ex_pc_i`.
  - Hit, taken: `ctr` = min(ctr+1, 3); `target` ← `ex_target_i`.
  - Hit, not taken: `ctr` = max(ctr−1, 0); `target` is unchanged.
  - Miss, taken: allocate. `valid`=1, write the tag, `target` ← `ex_target_i`, `ctr`=2. The previous occupant is overwritten.
  - Miss, not taken: table unchanged.
- Misprediction occurs when `ex_taken_i` ≠ `ex_pred_taken_i`, or when both are 1 and `ex_target_i` ≠ `ex_pred_target_i`.
- On an update cycle `br_count_o` increments by 1, and `mispred_count_o` also increments by 1 if the update is a misprediction. Both counters wrap at 2^32.
- `flush_i` clears every `valid` bit. Counters and stored targets are left as they are. The statistics counters are not affected.

## Timing
- Reset (`rst_ni`=0 at an edge):
  - All `valid`, `ctr`, `target` and `tag` cleared.
  - Both statistics counters = 0.
  - Result: `br_sel_BTB_o`=0 and `pc_BTB_o`=`if_pc_i+4` in the cycle after.
- Reset has priority over flush and update. An update presented in the reset cycle is dropped.
- Lookup latency is 0 cycles (combinational from `if_pc_i`). Update latency is 1 cycle: it is visible to lookups from the next cycle.
- Lookup and update of the same index in the same cycle: the lookup returns the pre-update contents. No bypass.
- `flush_i` together with `ex_update_i`: the flush is applied after the update, so the table ends fully invalid. The statistics counters still count the update.
- Counter saturation: `ctr`=3 with taken stays 3; `ctr`=0 with not-taken stays 0.
- Tag aliasing between two PCs that share an index: the most recent allocating branch wins.

## Structure
- Shared package `btb_pkg`:
  - `BTB_ENTRIES_DEF`.
  - typedef `btb_entry_t` {valid, tag, target, ctr}.
  - constants `CTR_WNT`=2'd1 and `CTR_WT`=2'd2 (allocation value).
  - Opcode constants come from the existing shared constants file.
- Sub-module `sat_counter2`: pure combinational next-value function for the 2-bit saturating counter (inputs `ctr`, `taken`). Instantiated once on the update path.
- Table stored in flops (an array of `btb_entry_t`). No SRAM.

## Test plan
- Reset, then lookup PC 0x100: `br_sel_BTB_o`=0, `pc_BTB_o`=0x104, both counters 0.
- Update pc=0x100, taken, target=0x200 (predicted not taken); next-cycle lookup 0x100: `br_sel_BTB_o`=1, `pc_BTB_o`=0x200, `mispred_count_o`=1, `br_count_o`=1.
- Train PC 0x100 taken twice (ctr=3), then not-taken twice: prediction stays taken after the first not-taken (ctr=2) and becomes not-taken after the second (ctr=1). A further not-taken saturates at 0.
- Hit-taken with a new target 0x300, predicted 0x200: mispredict counted, and the next lookup returns 0x300. PC 0x140 (same index, ENTRIES=16) allocates and evicts 0x100, so lookup 0x100 misses.
- Same-cycle lookup and update of 0x100: the lookup shows the old prediction and the new value appears the following cycle. `flush_i` with an update: all lookups miss afterwards, and `br_count_o` still increments.
- Assert `rst_ni`=0 during an update mid-training: the table and counters return to reset values, and the update is not applied.
